// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode types: FSM states, IF/ID bundle and widths.
// Imported by the fetch stage and by the downstream ID stage.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = '0;

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_WAIT,
      S_HELD
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
      logic               valid;
   } if_id_t;

   function automatic logic [ADDR_W-1:0] next_word(
      input logic [ADDR_W-1:0] a
   );
      return a + ADDR_W'(4);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus plus the IF/ID outputs to decode.
// master = fetch stage, slave = memory / ID side.
interface fetch_stage_if;
   import fetch_pkg::*;

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ready;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] if_id_instr;
   logic [ADDR_W-1:0]  if_id_pc;
   logic               if_id_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata,
      output if_id_instr,
      output if_id_pc,
      output if_id_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata,
      input  if_id_instr,
      input  if_id_pc,
      input  if_id_valid
   );

endinterface

// File: rtl/fetch_pc_unit.sv
// PC/nPC pair and the pending-redirect latch. Advances only on a
// completion; a redirect with no completion waits for the next one.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_complete,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_target,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_redirect
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_npc;
   logic              r_pend_valid;
   logic [ADDR_W-1:0] r_pend_target;

   logic              w_redir;
   logic [ADDR_W-1:0] w_target;

   // A fresh redirect supersedes whatever is pending.
   assign w_target = i_redirect ? i_redirect_target : r_pend_target;
   assign w_redir  = i_complete & (i_redirect | r_pend_valid);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc  <= RESET_PC;
         r_npc <= next_word(RESET_PC);
      end else if (w_redir) begin
         r_pc  <= w_target;
         r_npc <= next_word(w_target);
      end else if (i_complete) begin
         r_pc  <= r_npc;
         r_npc <= next_word(r_npc);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend_valid  <= 1'b0;
         r_pend_target <= '0;
      end else if (w_redir) begin
         r_pend_valid  <= 1'b0;
      end else if (i_redirect) begin
         r_pend_valid  <= 1'b1;
         r_pend_target <= i_redirect_target;
      end
   end

   assign o_pc       = r_pc;
   assign o_redirect = w_redir;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: fetch FSM, stall hold buffer and IF/ID register.
// FETCH_DELAY_SLOT_EN keeps the word fetched alongside a redirect.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   fetch_stage_if.master     bus
);

   fetch_state_e       r_state;
   fetch_state_e       w_state_nxt;
   logic [INSTR_W-1:0] r_hold_buf;
   if_id_t             r_if_id;

   logic               w_req;
   logic               w_fire;
   logic               w_complete;
   logic               w_redir_req;
   logic               w_redirect;
   logic               w_keep;
   logic [INSTR_W-1:0] w_word;
   logic [ADDR_W-1:0]  w_pc;
   if_id_t             w_bubble;
   if_id_t             w_fetched;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_BOOT;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_BOOT:  w_state_nxt = S_FETCH;
         S_FETCH: if (w_req && !bus.imem_ready) w_state_nxt = S_WAIT;
         S_WAIT:  if (bus.imem_ready)
                     w_state_nxt = stall ? S_HELD : S_FETCH;
         S_HELD:  if (!stall) w_state_nxt = S_FETCH;
         default: w_state_nxt = S_BOOT;
      endcase
   end

   // An outstanding request is never withdrawn, even under stall.
   always_comb begin
      w_req = 1'b0;
      case (r_state)
         S_FETCH: w_req = !stall;
         S_WAIT:  w_req = 1'b1;
         default: w_req = 1'b0;
      endcase
   end

   assign w_fire      = w_req & bus.imem_ready;
   assign w_complete  = !stall & (w_fire | (r_state == S_HELD));
   assign w_word      = (r_state == S_HELD) ? r_hold_buf : bus.imem_rdata;
   assign w_redir_req = branch_taken & !stall;

   fetch_pc_unit #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk               (clk),
      .reset_n           (reset_n),
      .i_complete        (w_complete),
      .i_redirect        (w_redir_req),
      .i_redirect_target (branch_target),
      .o_pc              (w_pc),
      .o_redirect        (w_redirect)
   );

`ifdef FETCH_DELAY_SLOT_EN
   assign w_keep = w_complete;
`else
   assign w_keep = w_complete & !w_redirect;
`endif

   assign w_bubble  = '{instr: NOP_INSTR, pc: w_pc, valid: 1'b0};
   assign w_fetched = '{instr: w_word, pc: w_pc, valid: 1'b1};

   // Word returning under stall is parked until the stall lifts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              r_hold_buf <= NOP_INSTR;
      else if (w_fire && stall)  r_hold_buf <= bus.imem_rdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_if_id <= '{instr: NOP_INSTR, pc: RESET_PC, valid: 1'b0};
      else if (flush)
         r_if_id <= w_bubble;
      else if (!stall)
         r_if_id <= w_keep ? w_fetched : w_bubble;
   end

   assign bus.imem_req    = w_req;
   assign bus.imem_addr   = w_pc;
   assign bus.if_id_instr = r_if_id.instr;
   assign bus.if_id_pc    = r_if_id.pc;
   assign bus.if_id_valid = r_if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic,
// against a transaction-level model; honours FETCH_DELAY_SLOT_EN.
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0;
   localparam logic [31:0] NOP    = NOP_INSTR_DEF;
   localparam logic [31:0] MEMTAG = 32'h1000_0000;
`ifdef FETCH_DELAY_SLOT_EN
   localparam bit DSLOT = 1'b1;
`else
   localparam bit DSLOT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;

   fetch_stage_if bus();

   fetch_stage #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .bus           (bus.master)
   );

   assign bus.imem_rdata = MEMTAG + bus.imem_addr;

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // model: fetch address, outstanding/parked transaction, pending jump
   bit          m_boot;
   bit          m_out;
   bit          m_park;
   logic [31:0] m_pword;
   logic [31:0] m_pc;
   logic [31:0] m_npc;
   bit          m_pend;
   logic [31:0] m_ptgt;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;
   bit          m_ival;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_boot  = 1'b1;
      m_out   = 1'b0;
      m_park  = 1'b0;
      m_pword = '0;
      m_pc    = RST_PC;
      m_npc   = RST_PC + 32'd4;
      m_pend  = 1'b0;
      m_ptgt  = '0;
      m_instr = NOP;
      m_ipc   = RST_PC;
      m_ival  = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   32'(bus.imem_req), 32'd0);
      chk({tag, "_addr"},  bus.imem_addr, RST_PC);
      chk({tag, "_valid"}, 32'(bus.if_id_valid), 32'd0);
      chk({tag, "_pc"},    bus.if_id_pc, RST_PC);
      chk({tag, "_instr"}, bus.if_id_instr, NOP);
   endtask

   // One clock: drive at negedge, check, advance model, next negedge.
   task automatic cyc(input bit st, input bit fl, input bit bt,
                      input logic [31:0] tg, input bit rdy);
      bit          req, fire, take, br, redir;
      logic [31:0] word, tgt, cur;
      stall          = st;
      flush          = fl;
      branch_taken   = bt;
      branch_target  = tg;
      bus.imem_ready = rdy;
      #1;
      req = !m_boot && !m_park && (m_out || !st);
      chk("imem_req",    32'(bus.imem_req), 32'(req));
      chk("imem_addr",   bus.imem_addr, m_pc);
      chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_ival));
      chk("if_id_pc",    bus.if_id_pc, m_ipc);
      chk("if_id_instr", bus.if_id_instr, m_instr);
      cur  = m_pc;
      fire = req && rdy;
      take = 1'b0;
      word = '0;
      if (!st && m_park) begin
         take   = 1'b1;
         word   = m_pword;
         m_park = 1'b0;
      end else if (!st && fire) begin
         take = 1'b1;
         word = MEMTAG + cur;
      end
      if (st && fire) begin
         m_park  = 1'b1;
         m_pword = MEMTAG + cur;
      end
      m_out = req && !rdy;
      br    = bt && !st;
      redir = 1'b0;
      tgt   = '0;
      if (take && (br || m_pend)) begin
         redir  = 1'b1;
         tgt    = br ? tg : m_ptgt;
         m_pend = 1'b0;
      end else if (br) begin
         m_pend = 1'b1;
         m_ptgt = tg;
      end
      if (fl || (!st && !(take && (DSLOT || !redir)))) begin
         m_instr = NOP;
         m_ipc   = cur;
         m_ival  = 1'b0;
      end else if (!st) begin
         m_instr = word;
         m_ipc   = cur;
         m_ival  = 1'b1;
      end
      if (take) begin
         m_pc  = redir ? tgt : m_npc;
         m_npc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      bus.imem_ready = 1'b0;
      model_reset();
      #2;
      chk_reset_outputs("por");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // zero-wait stream: first valid on second posedge after release
      run(2);
      chk("first_valid", 32'(bus.if_id_valid), 32'd1);
      chk("first_pc", bus.if_id_pc, RST_PC);
      // three wait cycles at pc 8
      run(1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
      run(2);
      // branch to 0x40 fetched with pc 0x10
      chk("br_at_pc", bus.imem_addr, 32'h10);
      cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
      chk("redir_addr", bus.imem_addr, 32'h40);
      run(2);
      // stall lands while in WAIT
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("held_req", 32'(bus.imem_req), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
      run(2);
      // branch during WAIT, applied at completion
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk("br_wait_addr", bus.imem_addr, 32'h40);
      run(2);
      // address wraps past the top of memory
      cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
      run(4);
      // flush on a stalled cycle
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
      run(2);

      // asynchronous reset in the middle of WAIT
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk_reset_outputs("mid_wait");
      @(negedge clk);
      model_reset();
      reset_n = 1'b1;
      run(2);
      chk("restart_pc", bus.if_id_pc, RST_PC);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bit          st, fl, bt, rdy;
         logic [31:0] tg;
         st  = ($urandom_range(0, 99) < 20);
         fl  = ($urandom_range(0, 99) < 8);
         bt  = ($urandom_range(0, 99) < 10);
         rdy = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 15) == 0)
            tg = 32'hFFFF_FFF0;
         else
            tg = 32'($urandom_range(0, 255)) << 2;
         cyc(st, fl, bt, tg, rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
